// File: rtl/led_ser_pkg.sv
// Shared types and default sizing for the LED chain serializer.
package led_ser_pkg;

  localparam int PAT_W   = 17;
  localparam int CHAIN_W = 24;
  localparam int DIV     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } ser_state_t;

endpackage

// File: rtl/bus_sync_stable.sv
// Three-flop bus synchronizer; o_stable flags two equal consecutive synchronized samples.
module bus_sync_stable #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q,
  output logic         o_stable
);

  logic [W-1:0] r_s1;
  logic [W-1:0] r_s2;
  logic [W-1:0] r_s3;
  logic [2:0]   r_fill;

  // NOTE: non-blocking assignments keep s1/s2/s3 a true 3-stage pipeline; blocking would collapse it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= '0;
      r_s2   <= '0;
      r_s3   <= '0;
      r_fill <= '0;
    end else begin
      r_s1   <= i_d;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_fill <= {r_fill[1:0], 1'b1};
    end
  end

  // The zeroed reset contents would otherwise look "stable" and launch a bogus all-zero frame.
  assign o_q      = r_s2;
  assign o_stable = r_fill[2] && (r_s2 == r_s3);

endmodule

// File: rtl/led_chain_serializer.sv
// Ships a synchronized LED pattern MSB first into a 74HC595-style chain, then latches it.
module led_chain_serializer #(
  parameter int PAT_W   = led_ser_pkg::PAT_W,
  parameter int CHAIN_W = led_ser_pkg::CHAIN_W,
  parameter int DIV     = led_ser_pkg::DIV
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PAT_W-1:0] pat_i,
  input  logic             refresh,
  output logic             ser_data,
  output logic             ser_clk,
  output logic             ser_latch,
  output logic             busy
);
  import led_ser_pkg::*;

  localparam int BIT_W = $clog2(CHAIN_W);
  localparam int PH_W  = $clog2(2 * DIV);
  localparam logic [PH_W-1:0]  PH_HALF  = PH_W'(DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2 * DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CHAIN_W - 1);

  ser_state_t         r_state;
  logic [CHAIN_W-1:0] r_shadow;
  logic [PAT_W-1:0]   r_last;
  logic               r_sent_valid;
  logic               r_refresh_pend;
  logic [BIT_W-1:0]   r_bit;
  logic [PH_W-1:0]    r_phase;

  logic [PAT_W-1:0]   w_s2;
  logic               w_stable;
  logic [CHAIN_W-1:0] w_frame;
  logic               w_start;

  bus_sync_stable #(.W(PAT_W)) u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_d      (pat_i),
    .o_q      (w_s2),
    .o_stable (w_stable)
  );

  assign w_frame = CHAIN_W'(w_s2);
  assign w_start = (r_state == IDLE) && w_stable &&
                   ((w_s2 != r_last) || !r_sent_valid || r_refresh_pend);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_shadow       <= '0;
      r_last         <= '0;
      r_sent_valid   <= 1'b0;
      r_refresh_pend <= 1'b0;
      r_bit          <= '0;
      r_phase        <= '0;
      ser_data       <= 1'b0;
      ser_clk        <= 1'b0;
      ser_latch      <= 1'b0;
      busy           <= 1'b0;
    end else begin
      if (refresh) r_refresh_pend <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_state        <= SHIFT;
            r_shadow       <= w_frame;
            r_last         <= w_s2;
            r_sent_valid   <= 1'b1;
            // A refresh arriving on the start edge itself still earns its own frame.
            r_refresh_pend <= refresh;
            r_bit          <= '0;
            r_phase        <= '0;
            ser_data       <= w_frame[CHAIN_W-1];
            ser_clk        <= 1'b0;
            busy           <= 1'b1;
          end
        end
        SHIFT: begin
          r_phase <= (r_phase == PH_LAST) ? '0 : r_phase + 1'b1;
          if (r_phase == PH_HALF) ser_clk <= 1'b1;
          if (r_phase == PH_LAST) begin
            ser_clk <= 1'b0;
            if (r_bit == BIT_LAST) begin
              r_state   <= LATCH;
              ser_data  <= 1'b0;
              ser_latch <= 1'b1;
            end else begin
              r_bit    <= r_bit + 1'b1;
              r_shadow <= {r_shadow[CHAIN_W-2:0], 1'b0};
              ser_data <= r_shadow[CHAIN_W-2];
            end
          end
        end
        LATCH: begin
          r_phase <= r_phase + 1'b1;
          if (r_phase == PH_HALF) begin
            r_state   <= IDLE;
            r_phase   <= '0;
            ser_latch <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_led_chain_serializer.sv
// Directed bench: a 74HC595 chain model records every latched frame and its timing.
module tb_led_chain_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [16:0] pat_i;
  logic        refresh;
  logic        ser_data, ser_clk, ser_latch, busy;

  int n_checks = 0;
  int n_fail   = 0;

  led_chain_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pat_i     (pat_i),
    .refresh   (refresh),
    .ser_data  (ser_data),
    .ser_clk   (ser_clk),
    .ser_latch (ser_latch),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Chain model and per-frame measurements, sampled mid-cycle.
  logic [23:0] chain_sr, chain_q;
  logic        prev_busy, prev_clk, prev_latch, prev_data;
  int          f_len, f_lat, f_rise, f_first, f_viol, idle_cnt, start_gap;
  int          latch_pulses = 0;
  logic [23:0] q_word[$];
  int          q_len[$], q_lat[$], q_rise[$], q_first[$], q_viol[$], q_gap[$];

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy  <= 1'b0;
      prev_clk   <= 1'b0;
      prev_latch <= 1'b0;
      prev_data  <= 1'b0;
      idle_cnt   <= 0;
    end else begin
      prev_busy  <= busy;
      prev_clk   <= ser_clk;
      prev_latch <= ser_latch;
      prev_data  <= ser_data;
      idle_cnt   <= busy ? 0 : idle_cnt + 1;
      if (ser_clk && !prev_clk) chain_sr <= {chain_sr[22:0], ser_data};
      if (ser_latch && !prev_latch) begin
        chain_q      <= chain_sr;
        latch_pulses <= latch_pulses + 1;
      end
      if (busy && !prev_busy) begin
        f_len     <= 1;
        f_lat     <= int'(ser_latch);
        f_rise    <= 0;
        f_first   <= -1;
        f_viol    <= int'(ser_clk);
        start_gap <= idle_cnt;
      end else if (busy) begin
        f_len  <= f_len + 1;
        f_lat  <= f_lat + int'(ser_latch);
        f_viol <= f_viol + int'(ser_clk && prev_clk && (ser_data != prev_data))
                         + int'(ser_latch && (ser_data || ser_clk));
        if (ser_clk && !prev_clk) begin
          f_rise <= f_rise + 1;
          if (f_first < 0) f_first <= f_len;
        end
      end else if (prev_busy) begin
        q_word.push_back(chain_q);
        q_len.push_back(f_len);
        q_lat.push_back(f_lat);
        q_rise.push_back(f_rise);
        q_first.push_back(f_first);
        q_viol.push_back(f_viol);
        q_gap.push_back(start_gap);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic pulse_refresh();
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
  endtask

  task automatic wait_busy(input int budget, input string name);
    int i;
    for (i = 0; i < budget && !busy; i++) tick();
    check({name, " busy rose"}, 32'(busy), 32'd1);
  endtask

  task automatic wait_frames(input int target, input int budget, input string name);
    for (int i = 0; i < budget && q_word.size() < target; i++) tick();
    check({name, " frame count"}, q_word.size(), target);
  endtask

  task automatic check_frame(input int idx, input logic [23:0] exp_word, input string tag);
    if (idx >= q_word.size()) begin
      check({tag, " frame present"}, q_word.size(), idx + 1);
    end else begin
      check({tag, " word"},        q_word[idx],  exp_word);
      check({tag, " busy len"},    q_len[idx],   196);
      check({tag, " latch len"},   q_lat[idx],   4);
      check({tag, " clk rises"},   q_rise[idx],  24);
      check({tag, " first rise"},  q_first[idx], 4);
      check({tag, " violations"},  q_viol[idx],  0);
    end
  endtask

  typedef struct {
    logic [16:0] pat;
    logic [23:0] exp_word;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int base;
    int lp;
    logic saw_busy;

    vecs[0] = '{17'h00001, 24'h000001};
    vecs[1] = '{17'h00003, 24'h000003};
    vecs[2] = '{17'h1FFFF, 24'h01FFFF};
    vecs[3] = '{17'h15555, 24'h015555};
    vecs[4] = '{17'h0AAAA, 24'h00AAAA};
    vecs[5] = '{17'h10001, 24'h010001};
    vecs[6] = '{17'h00000, 24'h000000};
    vecs[7] = '{17'h00018, 24'h000018};

    // Reset with the pattern already present.
    rst_n   = 1'b0;
    refresh = 1'b0;
    pat_i   = 17'h00018;
    repeat (4) tick();
    check("reset outputs", {28'd0, ser_data, ser_clk, ser_latch, busy}, 32'd0);
    rst_n = 1'b1;
    wait_frames(1, 400, "power-up");
    check_frame(0, 24'h000018, "power-up");
    repeat (2000) tick();
    check("no spurious frame", q_word.size(), 1);

    // Pattern changes mid-frame: current frame completes, then the new one follows.
    base = q_word.size();
    pulse_refresh();
    wait_busy(20, "midchange");
    repeat (40) tick();
    pat_i = 17'h00030;
    wait_frames(base + 2, 800, "midchange");
    check_frame(base, 24'h000018, "midchange old");
    check_frame(base + 1, 24'h000030, "midchange new");
    if (q_gap.size() > base + 1) check("midchange gap<=4", 32'(q_gap[base + 1] <= 4), 32'd1);

    // Idle refresh resends once.
    base = q_word.size();
    pulse_refresh();
    wait_frames(base + 1, 400, "refresh idle");
    repeat (500) tick();
    check("refresh idle count", q_word.size(), base + 1);
    check_frame(base, 24'h000030, "refresh idle");

    // Two refreshes inside one frame yield exactly one extra frame.
    base = q_word.size();
    pulse_refresh();
    wait_busy(20, "double refresh");
    repeat (20) tick();
    pulse_refresh();
    repeat (80) tick();
    pulse_refresh();
    wait_frames(base + 2, 800, "double refresh");
    repeat (600) tick();
    check("double refresh count", q_word.size(), base + 2);
    check_frame(base + 1, 24'h000030, "double refresh extra");

    // Reset mid-frame: outputs drop at once, no latch, full resend afterwards.
    base = q_word.size();
    lp   = latch_pulses;
    pulse_refresh();
    wait_busy(20, "abort");
    repeat (50) tick();
    rst_n = 1'b0;
    #1;
    check("abort outputs low", {29'd0, ser_data, ser_clk, busy}, 32'd0);
    check("abort latch low", 32'(ser_latch), 32'd0);
    repeat (5) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("abort no latch", latch_pulses, lp);
    check("abort chain holds", chain_q, 24'h000030);
    wait_frames(base + 1, 400, "abort resend");
    check_frame(base, 24'h000030, "abort resend");

    // Toggling input never looks stable; the settled value is sent once.
    base     = q_word.size();
    saw_busy = 1'b0;
    for (int i = 0; i < 10; i++) begin
      pat_i = (i % 2 == 0) ? 17'h00018 : 17'h08000;
      tick();
      saw_busy |= busy;
    end
    check("toggle no frame", 32'(saw_busy), 32'd0);
    pat_i = 17'h10000;
    wait_frames(base + 1, 400, "toggle settle");
    repeat (300) tick();
    check("toggle settle count", q_word.size(), base + 1);
    check_frame(base, 24'h010000, "toggle settle");

    // Bounce sequence of updates spaced 300 cycles apart.
    for (int v = 0; v < 8; v++) begin
      base  = q_word.size();
      pat_i = vecs[v].pat;
      repeat (300) tick();
      check($sformatf("bounce %0d count", v), q_word.size(), base + 1);
      check($sformatf("bounce %0d chain", v), chain_q, vecs[v].exp_word);
      if (q_word.size() > base)
        check($sformatf("bounce %0d word", v), q_word[base], vecs[v].exp_word);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
